// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit (SD) arithmetic blocks: digit
// encodings, digit width and the serial converter's state type.
package sd_pkg;

  localparam int SD_W = 2;

  localparam logic [SD_W-1:0] SD_ZERO = 2'b00;
  localparam logic [SD_W-1:0] SD_POS  = 2'b01;
  localparam logic [SD_W-1:0] SD_NEG  = 2'b11;
  localparam logic [SD_W-1:0] SD_BAD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } sd_state_t;

endpackage

// File: rtl/sd_digit_decode.sv
// Decodes one 2-bit SD digit into a signed value in {-1,0,+1}; the reserved
// code decodes as 0 and raises bad.
module sd_digit_decode
  import sd_pkg::*;
(
  input  logic [SD_W-1:0]        digit,
  output logic signed [SD_W-1:0] value,
  output logic                   bad
);

  always_comb begin
    value = 2'sb00;
    bad   = 1'b0;
    case (digit)
      SD_POS:  value = 2'sb01;
      SD_NEG:  value = 2'sb11;
      SD_BAD:  bad   = 1'b1;
      default: value = 2'sb00;
    endcase
  end

endmodule

// File: rtl/sd_to_bin_serial.sv
// Digit-serial SD to two's-complement converter: accepts NDIG sum digits plus
// a carry digit and accumulates one digit per cycle, LSB first.
module sd_to_bin_serial
  import sd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*NDIG-1:0]      in_sum,
  input  logic [1:0]             in_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NDIG+1:0]        out_value,
  output logic                   out_err
);

  localparam int OW = NDIG + 2;
  localparam int DW = SD_W * (NDIG + 1);
  localparam int IW = $clog2(NDIG + 1);

  // Handshakes: a transfer happens on a clock edge where valid && ready are
  // both high. in_ready is high only in IDLE; out_valid/out_value/out_err
  // stay stable in DONE until out_ready is seen high at an edge.
  sd_state_t             state;
  logic [DW-1:0]         sr;
  logic [OW-1:0]         acc;
  logic                  err;
  logic [IW-1:0]         idx;

  logic signed [SD_W-1:0] d_val;
  logic                   d_bad;
  logic [OW-1:0]          term;
  logic [OW-1:0]          acc_next;
  logic                   err_next;

  sd_digit_decode u_dec (
    .digit (sr[SD_W-1:0]),
    .value (d_val),
    .bad   (d_bad)
  );

  // Sign-extend the digit to full width, then weight it by 2^idx.
  assign term     = {{(OW-SD_W){d_val[SD_W-1]}}, d_val} << idx;
  assign acc_next = acc + term;
  assign err_next = err | d_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      acc       <= '0;
      err       <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_value <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= CONV;
            sr       <= {in_cout, in_sum};
            acc      <= '0;
            err      <= 1'b0;
            idx      <= '0;
            in_ready <= 1'b0;
          end
        end
        CONV: begin
          acc <= acc_next;
          err <= err_next;
          sr  <= {{SD_W{1'b0}}, sr[DW-1:SD_W]};
          idx <= idx + 1'b1;
          // The carry digit is the last one; publish the result directly.
          if (idx == IW'(NDIG)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_value <= acc_next;
            out_err   <= err_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_value <= '0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_value <= '0;
          out_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_to_bin_serial.sv
// Self-checking bench for sd_to_bin_serial: scenario tasks drive conversions,
// a reference sum fills the expected queue, and results are compared inline.
module tb_sd_to_bin_serial;

  localparam int NDIG = 4;
  localparam int OW   = NDIG + 2;
  localparam int W    = OW + 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2*NDIG-1:0] in_sum;
  logic [1:0]        in_cout;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_value;
  logic              out_err;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  sd_to_bin_serial #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: {err, value} from the digit definition.
  function automatic logic [W-1:0] ref_conv(input logic [2*NDIG-1:0] s, input logic [1:0] c);
    int sum;
    logic bad;
    logic [1:0] d;
    logic [OW-1:0] v;
    sum = 0;
    bad = 1'b0;
    for (int i = 0; i <= NDIG; i++) begin
      d = (i < NDIG) ? s[2*i +: 2] : c;
      if (d == 2'b01) sum = sum + (1 << i);
      else if (d == 2'b11) sum = sum - (1 << i);
      else if (d == 2'b10) bad = 1'b1;
    end
    v = sum[OW-1:0];
    return {bad, v};
  endfunction

  // Driver tasks; all sampling happens #1 after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [2*NDIG-1:0] s, input logic [1:0] c, input bit push);
    int n;
    n = 0;
    in_sum   = s;
    in_cout  = c;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sum   = $urandom_range(0, 255);
    in_cout  = $urandom_range(0, 3);
    if (push) exp_q.push_back(ref_conv(s, c));
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!out_valid && cycles < 20);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  // Scenarios
  task automatic test_reset();
    do_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_value !== '0) begin n_fail++; $display("FAIL reset_out_value: got %0h expected 0", out_value); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
  endtask

  task automatic test_basic();
    int cyc;
    logic [W-1:0] e;
    send(8'b00_01_00_01, 2'b00, 1'b1);
    wait_out(cyc);
    e = pop_exp();
    n_checks++; if (cyc != 5 || out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %0d cycles valid=%b expected 5 cycles", cyc, out_valid); end
    n_checks++; if (out_value !== 6'd5 || out_value !== e[OW-1:0]) begin n_fail++; $display("FAIL basic_value: got %0d expected 5", $signed(out_value)); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", out_err); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_done: got %b expected 0", in_ready); end
    release_out();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    n_checks++; if (out_value !== '0 || out_err !== 1'b0) begin n_fail++; $display("FAIL basic_idle_zero: got value=%0h err=%b expected 0/0", out_value, out_err); end
  endtask

  task automatic test_neg_full();
    int cyc;
    logic [W-1:0] e;
    send(8'b11_11_11_11, 2'b11, 1'b1);
    wait_out(cyc);
    e = pop_exp();
    n_checks++; if (out_valid !== 1'b1 || out_value !== 6'b100001 || out_value !== e[OW-1:0]) begin n_fail++; $display("FAIL neg_full_value: got %b expected 100001", out_value); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL neg_full_err: got %b expected 0", out_err); end
    release_out();
  endtask

  task automatic test_redundant();
    int cyc;
    logic [W-1:0] e;
    logic [1:0] d2_tab[3];
    logic [7:0] s;
    d2_tab[0] = 2'b00; d2_tab[1] = 2'b01; d2_tab[2] = 2'b11;
    send(8'b01_11_01_11, 2'b01, 1'b1);
    wait_out(cyc);
    e = pop_exp();
    n_checks++; if (out_valid !== 1'b1 || out_value !== 6'd21 || out_value !== e[OW-1:0]) begin n_fail++; $display("FAIL redundant_21: got %0d expected 21", $signed(out_value)); end
    release_out();
    for (int k = 0; k < 3; k++) begin
      s = 8'b01_01_01_01;
      s[5:4] = d2_tab[k];
      send(s, 2'b00, 1'b1);
      wait_out(cyc);
      e = pop_exp();
      n_checks++; if (out_valid !== 1'b1 || out_value !== e[OW-1:0] || out_err !== e[OW]) begin n_fail++; $display("FAIL redundant_d2_%0d: got %0d err=%b expected %0d err=%b", k, $signed(out_value), out_err, $signed(e[OW-1:0]), e[OW]); end
      release_out();
    end
  endtask

  task automatic test_illegal();
    int cyc;
    logic [W-1:0] e;
    send(8'b00_10_00_01, 2'b00, 1'b1);
    wait_out(cyc);
    e = pop_exp();
    n_checks++; if (out_valid !== 1'b1 || out_value !== 6'd1 || out_value !== e[OW-1:0]) begin n_fail++; $display("FAIL illegal_value: got %0d expected 1", $signed(out_value)); end
    n_checks++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b expected 1", out_err); end
    release_out();
    send(8'b00_00_01_00, 2'b00, 1'b1);
    wait_out(cyc);
    e = pop_exp();
    n_checks++; if (out_valid !== 1'b1 || out_value !== 6'd2 || out_err !== 1'b0 || e[OW] !== 1'b0) begin n_fail++; $display("FAIL illegal_clears: got %0d err=%b expected 2 err=0", $signed(out_value), out_err); end
    release_out();
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [W-1:0] e;
    send(8'b11_00_01_01, 2'b01, 1'b1);
    wait_out(cyc);
    e = pop_exp();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_value !== e[OW-1:0] || out_err !== e[OW] || in_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure_hold_%0d: got valid=%b value=%0d err=%b in_ready=%b expected 1/%0d/%b/0", k, out_valid, $signed(out_value), out_err, in_ready, $signed(e[OW-1:0]), e[OW]); end
      in_valid = (k != 1);
      in_sum   = 8'b01_01_01_01;
      in_cout  = 2'b01;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_value !== e[OW-1:0] || in_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure_final: got valid=%b value=%0d in_ready=%b", out_valid, $signed(out_value), in_ready); end
    release_out();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    repeat (7) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_ignored: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_conv();
    int cyc;
    logic [W-1:0] e;
    send(8'b01_01_01_01, 2'b01, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_state: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    send(8'b00_00_00_01, 2'b00, 1'b1);
    wait_out(cyc);
    e = pop_exp();
    n_checks++; if (cyc != 5 || out_value !== 6'd1 || out_value !== e[OW-1:0] || out_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_fresh: got %0d err=%b after %0d cycles expected 1 err=0 after 5", $signed(out_value), out_err, cyc); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [W-1:0] e;
    logic [7:0] s;
    logic [1:0] c;
    for (int k = 0; k < 24; k++) begin
      s = $urandom_range(0, 255);
      c = $urandom_range(0, 3);
      send(s, c, 1'b1);
      wait_out(cyc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      e = pop_exp();
      n_checks++; if (out_valid !== 1'b1 || out_value !== e[OW-1:0] || out_err !== e[OW]) begin n_fail++; $display("FAIL random_%0d: sum=%b cout=%b got %0d err=%b expected %0d err=%b", k, s, c, $signed(out_value), out_err, $signed(e[OW-1:0]), e[OW]); end
      release_out();
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_empty: got %0d entries expected 0", exp_q.size()); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_cout   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_neg_full();
    test_redundant();
    test_illegal();
    test_backpressure();
    test_reset_mid_conv();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
